// File: rtl/phase_accumulator.sv
// DDS numerically controlled oscillator: 32-bit phase accumulator with offset,
// period-aligned retuning through a shadow register, burst mode and sync pulses.
module phase_accumulator #(
  parameter int ACC_WIDTH   = 32,
  parameter int PHASE_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [ACC_WIDTH-1:0]   cfg_ftw,
  input  logic [PHASE_WIDTH-1:0] cfg_offset,
  input  logic [15:0]            cfg_burst,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic                   phase_valid,
  output logic                   sync,
  output logic                   done,
  output logic                   busy
);

  // Config handshake: a word moves when cfg_valid && cfg_ready at a rising edge;
  // cfg_valid is not required to hold after that edge. busy mirrors the FSM state.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [ACC_WIDTH-1:0]   ftw_q, ftw_d, sh_ftw_q, sh_ftw_d;
  logic [PHASE_WIDTH-1:0] offset_q, offset_d, sh_offset_q, sh_offset_d;
  logic [15:0]            burst_q, burst_d, sh_burst_q, sh_burst_d;
  logic [15:0]            count_q, count_d;
  logic                   pend_q, pend_d;
  logic                   new_period_q, new_period_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic                   valid_q, valid_d;
  logic                   sync_q, sync_d;
  logic                   done_q, done_d;

  logic [ACC_WIDTH:0] sum;
  logic               carry;
  logic               cfg_xfer;
  logic               burst_end;
  logic               exit_run;

  assign sum       = {1'b0, acc_q} + {1'b0, ftw_q};
  assign carry     = sum[ACC_WIDTH];
  assign cfg_xfer  = cfg_valid && cfg_ready;
  assign burst_end = (burst_q != 16'd0) && carry && ((count_q + 16'd1) == burst_q);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    ftw_d        = ftw_q;
    offset_d     = offset_q;
    burst_d      = burst_q;
    sh_ftw_d     = sh_ftw_q;
    sh_offset_d  = sh_offset_q;
    sh_burst_d   = sh_burst_q;
    count_d      = count_q;
    pend_d       = pend_q;
    new_period_d = new_period_q;
    phase_d      = phase_q;
    valid_d      = valid_q;
    sync_d       = sync_q;
    done_d       = done_q;
    exit_run     = 1'b0;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        sync_d  = 1'b0;
        done_d  = 1'b0;
        if (cfg_xfer) begin
          ftw_d    = cfg_ftw;
          offset_d = cfg_offset;
          burst_d  = cfg_burst;
        end
        if (start) begin
          state_d      = RUN;
          acc_d        = '0;
          count_d      = 16'd0;
          new_period_d = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          valid_d  = 1'b0;
          sync_d   = 1'b0;
          done_d   = 1'b0;
          state_d  = IDLE;
          exit_run = 1'b1;
        end else begin
          phase_d      = acc_q[ACC_WIDTH-1 -: PHASE_WIDTH] + offset_q;
          valid_d      = 1'b1;
          sync_d       = new_period_q;
          acc_d        = sum[ACC_WIDTH-1:0];
          new_period_d = carry;
          done_d       = burst_end;
          if (carry) count_d = count_q + 16'd1;
          if (burst_end) begin
            state_d  = IDLE;
            acc_d    = '0;
            exit_run = 1'b1;
          end
        end

        // Leaving RUN must leave nothing pending, so IDLE always accepts config.
        if (exit_run) begin
          if (cfg_xfer) begin
            ftw_d    = cfg_ftw;
            offset_d = cfg_offset;
            burst_d  = cfg_burst;
          end else if (pend_q) begin
            ftw_d    = sh_ftw_q;
            offset_d = sh_offset_q;
            burst_d  = sh_burst_q;
          end
          pend_d = 1'b0;
        end else if (pend_q && carry) begin
          ftw_d    = sh_ftw_q;
          offset_d = sh_offset_q;
          burst_d  = sh_burst_q;
          pend_d   = 1'b0;
        end else if (cfg_xfer) begin
          sh_ftw_d    = cfg_ftw;
          sh_offset_d = cfg_offset;
          sh_burst_d  = cfg_burst;
          pend_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      ftw_q        <= '0;
      offset_q     <= '0;
      burst_q      <= 16'd0;
      sh_ftw_q     <= '0;
      sh_offset_q  <= '0;
      sh_burst_q   <= 16'd0;
      count_q      <= 16'd0;
      pend_q       <= 1'b0;
      new_period_q <= 1'b0;
      phase_q      <= '0;
      valid_q      <= 1'b0;
      sync_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      ftw_q        <= ftw_d;
      offset_q     <= offset_d;
      burst_q      <= burst_d;
      sh_ftw_q     <= sh_ftw_d;
      sh_offset_q  <= sh_offset_d;
      sh_burst_q   <= sh_burst_d;
      count_q      <= count_d;
      pend_q       <= pend_d;
      new_period_q <= new_period_d;
      phase_q      <= phase_d;
      valid_q      <= valid_d;
      sync_q       <= sync_d;
      done_q       <= done_d;
    end
  end

  assign cfg_ready   = !pend_q;
  assign phase       = phase_q;
  assign phase_valid = valid_q;
  assign sync        = sync_q;
  assign done        = done_q;
  assign busy        = (state_q == RUN);

endmodule

// File: tb/tb_phase_accumulator.sv
// Directed bench for phase_accumulator: sweep, burst, retune, stop/restart,
// start/stop priority, zero-ftw burst and mid-run reset.
module tb_phase_accumulator;

  logic        clk = 1'b0;
  logic        rst, start, stop, cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_ftw;
  logic [7:0]  cfg_offset;
  logic [15:0] cfg_burst;
  logic [7:0]  phase;
  logic        phase_valid, sync, done, busy;

  int total = 0;
  int bad   = 0;

  phase_accumulator #(.ACC_WIDTH(32), .PHASE_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ftw(cfg_ftw), .cfg_offset(cfg_offset), .cfg_burst(cfg_burst),
    .phase(phase), .phase_valid(phase_valid), .sync(sync),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_idle(input logic [31:0] f, input logic [7:0] o, input logic [15:0] b);
    cfg_valid = 1'b1; cfg_ftw = f; cfg_offset = o; cfg_burst = b;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  logic [7:0] burst_tbl [8];

  initial begin
    burst_tbl = '{8'h10, 8'h50, 8'h90, 8'hD0, 8'h10, 8'h50, 8'h90, 8'hD0};
    rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
    cfg_ftw = '0; cfg_offset = '0; cfg_burst = '0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_phase", 32'(phase), 32'h0);
    chk("rst_valid", 32'(phase_valid), 32'h0);
    chk("rst_sync", 32'(sync), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h1);

    // Full-circle sweep, one phase step per clock.
    cfg_idle(32'h0100_0000, 8'h00, 16'd0);
    do_start();
    for (int i = 0; i <= 256; i++) begin
      tick();
      chk("sweep_phase", 32'(phase), 32'(i & 255));
      chk("sweep_sync", 32'(sync), (i == 0 || i == 256) ? 32'h1 : 32'h0);
      chk("sweep_done", 32'(done), 32'h0);
    end
    do_stop();
    chk("sweep_stop_busy", 32'(busy), 32'h0);

    // Two-period burst with offset.
    cfg_idle(32'h4000_0000, 8'h10, 16'd2);
    do_start();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("burst_phase", 32'(phase), 32'(burst_tbl[i]));
      chk("burst_valid", 32'(phase_valid), 32'h1);
      chk("burst_sync", 32'(sync), (i == 0 || i == 4) ? 32'h1 : 32'h0);
      chk("burst_done", 32'(done), (i == 7) ? 32'h1 : 32'h0);
    end
    tick();
    chk("burst_end_valid", 32'(phase_valid), 32'h0);
    chk("burst_end_done", 32'(done), 32'h0);
    chk("burst_end_busy", 32'(busy), 32'h0);
    chk("burst_end_phase", 32'(phase), 32'hD0);

    // Retune mid-period: new ftw takes effect after the wrap.
    cfg_idle(32'h4000_0000, 8'h00, 16'd0);
    do_start();
    tick();
    chk("rt_e1", 32'(phase), 32'h00);
    cfg_valid = 1'b1; cfg_ftw = 32'h8000_0000; cfg_offset = 8'h00; cfg_burst = 16'd0;
    tick();
    cfg_valid = 1'b0;
    chk("rt_e2", 32'(phase), 32'h40);
    chk("rt_ready_e2", 32'(cfg_ready), 32'h0);
    tick();
    chk("rt_e3", 32'(phase), 32'h80);
    chk("rt_ready_e3", 32'(cfg_ready), 32'h0);
    tick();
    chk("rt_e4", 32'(phase), 32'hC0);
    chk("rt_ready_e4", 32'(cfg_ready), 32'h1);
    tick();
    chk("rt_e5", 32'(phase), 32'h00);
    chk("rt_sync_e5", 32'(sync), 32'h1);
    tick();
    chk("rt_e6", 32'(phase), 32'h80);
    chk("rt_sync_e6", 32'(sync), 32'h0);
    tick();
    chk("rt_e7", 32'(phase), 32'h00);
    chk("rt_sync_e7", 32'(sync), 32'h1);
    do_stop();

    // Stop on the third sample, then restart.
    cfg_idle(32'h4000_0000, 8'h05, 16'd0);
    do_start();
    tick();
    chk("st_s1", 32'(phase), 32'h05);
    tick();
    chk("st_s2", 32'(phase), 32'h45);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("st_valid", 32'(phase_valid), 32'h0);
    chk("st_hold", 32'(phase), 32'h45);
    chk("st_done", 32'(done), 32'h0);
    chk("st_busy", 32'(busy), 32'h0);
    tick();
    chk("st_done2", 32'(done), 32'h0);
    do_start();
    tick();
    chk("st_restart_phase", 32'(phase), 32'h05);
    chk("st_restart_sync", 32'(sync), 32'h1);
    chk("st_restart_valid", 32'(phase_valid), 32'h1);
    do_stop();

    // start+stop together: IDLE starts, RUN stops.
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_idle_busy", 32'(busy), 32'h1);
    tick();
    chk("ss_idle_phase", 32'(phase), 32'h05);
    chk("ss_idle_valid", 32'(phase_valid), 32'h1);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_run_busy", 32'(busy), 32'h0);
    chk("ss_run_valid", 32'(phase_valid), 32'h0);

    // ftw=0 with burst=1 never completes.
    cfg_idle(32'h0, 8'h33, 16'd1);
    do_start();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("z_phase", 32'(phase), 32'h33);
      chk("z_done", 32'(done), 32'h0);
      chk("z_busy", 32'(busy), 32'h1);
    end
    do_stop();

    // Reset with a shadow pending discards it.
    cfg_idle(32'h4000_0000, 8'h00, 16'd0);
    do_start();
    tick();
    cfg_valid = 1'b1; cfg_ftw = 32'h1234_5678; cfg_offset = 8'h77; cfg_burst = 16'd3;
    tick();
    cfg_valid = 1'b0;
    chk("rr_pending", 32'(cfg_ready), 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_phase", 32'(phase), 32'h0);
    chk("rr_valid", 32'(phase_valid), 32'h0);
    chk("rr_sync", 32'(sync), 32'h0);
    chk("rr_done", 32'(done), 32'h0);
    chk("rr_busy", 32'(busy), 32'h0);
    chk("rr_ready", 32'(cfg_ready), 32'h1);
    do_start();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_run_phase", 32'(phase), 32'h00);
      chk("rr_run_ready", 32'(cfg_ready), 32'h1);
    end
    do_stop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
